// File: rtl/logic_serial_32.sv
// ---------------------------------------------------------------------------
// logic_serial_32 -- bit-serial 32-bit logic engine
//
// Computes AND / OR / NOR / NOT A / BUF A of two operands, STEP bits per clock,
// under a start/done handshake. Smaller replacement for the parallel gate
// arrays on slow paths (debug / self-test datapath); the result is identical
// to the parallel gates for every legal opcode.
//
// Optional feature macro: LOGIC_SERIAL_ZERO_FLAG_EN (adds zero_o).
//
// Parameters
//   WIDTH    operand/result width, multiple of STEP
//   STEP     bits per cycle: 1, 2, 4 or 8
// Ports
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   start_i  request, accepted only while ready_o=1
//   op_i     opcode (000 AND, 001 OR, 010 NOR, 011 NOT A, 100 BUF A)
//   a_i,b_i  operands, sampled with an accepted start
//   ready_o  engine can accept start_i this cycle (IDLE or DONE)
//   busy_o   shifting in progress
//   done_o   one-cycle pulse, y_o/err_o valid
//   y_o      result, held until the next accepted op completes
//   err_o    last op used an illegal opcode (result forced to zero)
//   zero_o   (macro only) result of last op is all-zero
// ---------------------------------------------------------------------------
module logic_serial_32 #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] y_o,
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
    output logic             zero_o,
`endif
    output logic             err_o
);

    localparam int NSTEP = WIDTH / STEP;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    // Only the upper WIDTH-STEP result bits need storage: the newest slice
    // comes straight from the combinational slice logic.
    logic [WIDTH-STEP-1:0] res_q;
    logic [WIDTH-1:0]   y_q;
    logic               ready_q, busy_q, done_q, err_q;

    logic [STEP-1:0]    slice_d;
    logic               illegal_d;
    logic [WIDTH-1:0]   res_d;

`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
    logic               acc_q;   // OR of all slices produced so far
    logic               zero_q;
`endif

    // One STEP-wide slice of the selected function from the operand LSBs.
    always_comb begin
        slice_d   = '0;
        illegal_d = 1'b0;
        case (op_q)
            3'b000:  slice_d = a_q[STEP-1:0] & b_q[STEP-1:0];
            3'b001:  slice_d = a_q[STEP-1:0] | b_q[STEP-1:0];
            3'b010:  slice_d = ~(a_q[STEP-1:0] | b_q[STEP-1:0]);
            3'b011:  slice_d = ~a_q[STEP-1:0];
            3'b100:  slice_d = a_q[STEP-1:0];
            default: illegal_d = 1'b1;
        endcase
    end

    // New slice enters from the MSB end; after NSTEP slices bit 0 is LSB.
    assign res_d = {slice_d, res_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            y_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
            acc_q   <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        op_q    <= op_i;
                        cnt_q   <= '0;
                        state_q <= S_SHIFT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
                        acc_q   <= 1'b0;
`endif
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    // start_i is ignored here by construction.
                    a_q   <= a_q >> STEP;
                    b_q   <= b_q >> STEP;
                    res_q <= res_d[WIDTH-1:STEP];
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
                    acc_q <= acc_q | (|slice_d);
`endif
                    if (cnt_q == LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        y_q     <= res_d;
                        err_q   <= illegal_d;
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
                        zero_q  <= ~(acc_q | (|slice_d));
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign y_o     = y_q;
    assign err_o   = err_q;
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
    assign zero_o  = zero_q;
`endif

endmodule

// File: tb/tb_logic_serial_32.sv
// ---------------------------------------------------------------------------
// tb_logic_serial_32 -- bench for logic_serial_32.
// Two instances: [0] STEP=1 (32 cycles/op), [1] STEP=4 (8 cycles/op), sharing
// reset and operand/opcode inputs with separate start lines. A behavioural
// model (remaining-cycle count + pending result) is checked every cycle, plus
// literal expectations for the directed cases.
// ---------------------------------------------------------------------------
module tb_logic_serial_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  start_s = 2'b00;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0, b = '0;

    logic        ready_w [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic        err_w   [2];
    logic        zero_w  [2];
    logic [31:0] y_w     [2];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int nst [2] = '{32, 8};

    always #5 clk = ~clk;

    logic_serial_32 #(.WIDTH(32), .STEP(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[0]), .op_i(op), .a_i(a), .b_i(b),
        .ready_o(ready_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]), .y_o(y_w[0]),
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
        .zero_o(zero_w[0]),
`endif
        .err_o(err_w[0])
    );

    logic_serial_32 #(.WIDTH(32), .STEP(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[1]), .op_i(op), .a_i(a), .b_i(b),
        .ready_o(ready_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]), .y_o(y_w[1]),
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
        .zero_o(zero_w[1]),
`endif
        .err_o(err_w[1])
    );

`ifndef LOGIC_SERIAL_ZERO_FLAG_EN
    assign zero_w[0] = 1'b0;
    assign zero_w[1] = 1'b0;
`endif

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] t=%0t got %h want %h", nm, inst, $time, act, exp);
        end
    endtask

    // Parallel-gate reference: {err, result}.
    function automatic logic [32:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'b000:  return {1'b0, x & y};
            3'b001:  return {1'b0, x | y};
            3'b010:  return {1'b0, ~(x | y)};
            3'b011:  return {1'b0, ~x};
            3'b100:  return {1'b0, x};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // Model: m_rem = shift cycles still to go (0 => ready). Result published
    // on the edge where the count runs out.
    int          m_rem  [2];
    logic        m_done [2];
    logic        m_err  [2], p_err [2], m_zero [2];
    logic [31:0] m_y    [2], p_y   [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_rem[i]  <= 0;
                m_done[i] <= 1'b0;
                m_y[i]    <= '0;
                m_err[i]  <= 1'b0;
                m_zero[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_rem[i] > 0) begin
                    m_rem[i]  <= m_rem[i] - 1;
                    m_done[i] <= (m_rem[i] == 1);
                    if (m_rem[i] == 1) begin
                        m_y[i]    <= p_y[i];
                        m_err[i]  <= p_err[i];
                        m_zero[i] <= (p_y[i] == 32'h0);
                    end
                end else begin
                    m_done[i] <= 1'b0;
                    if (start_s[i]) begin
                        {p_err[i], p_y[i]} <= ref_op(op, a, b);
                        m_rem[i] <= nst[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("ready", i, 32'(ready_w[i]), 32'(m_rem[i] == 0));
                chk("busy",  i, 32'(busy_w[i]),  32'(m_rem[i] != 0));
                chk("done",  i, 32'(done_w[i]),  32'(m_done[i]));
                chk("y",     i, y_w[i],          m_y[i]);
                chk("err",   i, 32'(err_w[i]),   32'(m_err[i]));
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
                chk("zero",  i, 32'(zero_w[i]),  32'(m_zero[i]));
`endif
            end
        end
    end

    // Issue one op on instance i, scramble inputs afterwards, wait for DONE
    // and check latency and literal result.
    task automatic run_op(input int i, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ey, input logic ee);
        int k;
        @(negedge clk); op = o; a = x; b = y; start_s[i] = 1'b1;
        @(negedge clk); start_s[i] = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        k = 0;
        while (!done_w[i] && k < 100) begin @(negedge clk); k++; end
        chk("latency", i, 32'(k), 32'(nst[i]));
        chk("y_lit",   i, y_w[i], ey);
        chk("err_lit", i, 32'(err_w[i]), 32'(ee));
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
        chk("zero_lit", i, 32'(zero_w[i]), 32'(ey == 32'h0));
`endif
    endtask

    initial begin
        int k, seen;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 0, 32'(ready_w[0]), 32'd1);
        chk("rst_busy",  0, 32'(busy_w[0]),  32'd0);
        chk("rst_y",     0, y_w[0],          32'h0);
        chk("rst_err",   1, 32'(err_w[1]),   32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Directed ops, STEP=1.
        run_op(0, 3'b000, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0);
        run_op(0, 3'b010, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0);
        run_op(0, 3'b011, 32'h12345678, $urandom,     32'hEDCBA987, 1'b0);
        run_op(0, 3'b100, 32'hDEADBEEF, $urandom,     32'hDEADBEEF, 1'b0);
        run_op(0, 3'b110, $urandom,     $urandom,     32'h0,        1'b1);
        run_op(0, 3'b001, 32'h0000F0F0, 32'h00FF00FF, 32'h00FFF0FF, 1'b0);

        // START pulses at cycles 5 and 20 of a busy op are ignored.
        @(negedge clk); op = 3'b000; a = 32'hF0F0F0F0; b = 32'hFFFF0000; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        k = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done_w[0]) begin k = c; break; end
            start_s[0] = (c == 5 || c == 20);
            if (start_s[0]) begin a = $urandom; b = $urandom; op = 3'($urandom); end
        end
        start_s[0] = 1'b0;
        chk("ign_latency", 0, 32'(k), 32'd32);
        chk("ign_y",       0, y_w[0], 32'hF0F00000);

        // Back-to-back: START held high through the DONE cycle.
        @(negedge clk); op = 3'b000; a = 32'hFFFF0000; b = 32'h0F0F0F0F; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        repeat (28) @(negedge clk);
        op = 3'b001; a = 32'h1; b = 32'h2; start_s[0] = 1'b1;
        k = 0;
        while (!done_w[0] && k < 100) begin @(negedge clk); k++; end
        chk("b2b_first_y", 0, y_w[0], 32'h0F0F0000);
        @(negedge clk); start_s[0] = 1'b0;
        chk("b2b_busy", 0, 32'(busy_w[0]), 32'd1);
        k = 0;
        while (!done_w[0] && k < 100) begin @(negedge clk); k++; end
        chk("b2b_latency", 0, 32'(k), 32'd32);
        chk("b2b_y",       0, y_w[0], 32'h00000003);

        // Randomized traffic on both instances.
        repeat (400) begin
            @(negedge clk);
            start_s[0] = ($urandom_range(0, 3) == 0);
            start_s[1] = ($urandom_range(0, 2) == 0);
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
        end
        @(negedge clk); start_s = 2'b00;
        repeat (40) @(negedge clk);

        // STEP=4 instance.
        run_op(1, 3'b000, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0);
        run_op(1, 3'b110, $urandom,     $urandom,     32'h0,        1'b1);
        run_op(1, 3'b011, 32'h12345678, $urandom,     32'hEDCBA987, 1'b0);

        // Reset in the middle of an op: immediate reset, no DONE afterwards.
        @(negedge clk); op = 3'b100; a = 32'hDEADBEEF; b = $urandom; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 0, 32'(ready_w[0]), 32'd1);
        chk("mid_rst_busy",  0, 32'(busy_w[0]),  32'd0);
        chk("mid_rst_done",  0, 32'(done_w[0]),  32'd0);
        chk("mid_rst_y",     0, y_w[0],          32'h0);
        chk("mid_rst_err",   0, 32'(err_w[0]),   32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (40) begin @(negedge clk); if (done_w[0]) seen++; end
        chk("mid_rst_nodone", 0, 32'(seen), 32'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
